clk_div_meter: RTL

//  Measurement end of the clock-divider path. Samples a divided-clock signal
//  (async or same-domain) in the fast clk domain and measures high time, low

---
 rtl/clk_div_meter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/clk_div_meter.sv
// Measures high time, low time and period of a divided clock sampled in the clk domain,
// and reports period lock and a stuck (edgeless) input.
module clk_div_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int LOCK_N  = 4,
    parameter int TOL     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck,
    output logic [1:0]       dbg_state
);

    localparam int MC_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);
    localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hr_q;
    logic [CNT_W-1:0] high_q, low_q;
    logic [CNT_W:0]   period_q;
    logic [CNT_W:0]   prev_q;
    logic             prev_ok_q;
    logic [MC_W-1:0]  mc_q;
    logic             valid_q, locked_q, stuck_q;

    logic             rise, fall, evt, timeout_hit;
    logic [CNT_W:0]   period_new, diff;
    logic             match;
    logic [MC_W-1:0]  mc_inc;

    // sync_q[1] is the settled sample; sync_q[2] is its previous value.
    assign rise        = sync_q[1] & ~sync_q[2];
    assign fall        = ~sync_q[1] & sync_q[2];
    assign evt         = rise | fall;
    assign timeout_hit = !evt && (cnt_q == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (evt) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        period_new = {1'b0, hr_q} + {1'b0, cnt_q};
        diff       = (period_new >= prev_q) ? (period_new - prev_q) : (prev_q - period_new);
        match      = prev_ok_q && (diff <= TOL_C);
        mc_inc     = (mc_q == LOCK_C) ? mc_q : (mc_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hr_q      <= '0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
            mc_q      <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en) begin
                // Soft clear: measured values are kept, everything else restarts.
                state_q   <= IDLE;
                locked_q  <= 1'b0;
                stuck_q   <= 1'b0;
                mc_q      <= '0;
                prev_ok_q <= 1'b0;
            end else begin
                if (evt) begin
                    stuck_q <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                        end
                    end
                    HIGH, LOW: begin
                        if (state_q == HIGH && fall) begin
                            hr_q    <= cnt_q;
                            state_q <= LOW;
                        end else if (state_q == LOW && rise) begin
                            high_q    <= hr_q;
                            low_q     <= cnt_q;
                            period_q  <= period_new;
                            valid_q   <= 1'b1;
                            prev_q    <= period_new;
                            prev_ok_q <= 1'b1;
                            state_q   <= HIGH;
                            if (match) begin
                                mc_q <= mc_inc;
                                if (mc_inc == LOCK_C) begin
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                mc_q     <= '0;
                                locked_q <= 1'b0;
                            end
                        end else if (timeout_hit) begin
                            stuck_q   <= 1'b1;
                            locked_q  <= 1'b0;
                            mc_q      <= '0;
                            prev_ok_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign high_time  = high_q;
    assign low_time   = low_q;
    assign period     = period_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign stuck      = stuck_q;
    assign dbg_state  = state_q;

endmodule
